// File: rtl/divu.sv
// divu: multi-cycle unsigned restoring divider.
// One shift-subtract iteration per clock; q/r are registered and only change
// on the cycle the result becomes valid (done pulse).
// Optional feature macro: DIVU_ZERO_FAST_EN -- when defined, a zero divisor
// skips the iterative loop and reports its result right after acceptance.
module divu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;
  logic [WIDTH-1:0] iter_rem;
  logic [WIDTH-1:0] iter_dvd;
  logic             accept;
  logic             unused_sub_msb;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and shift the quotient bit
  // into the vacated LSB of the dividend register.
  always_comb begin
    rem_shift = {rem_q, dvd_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    rem_ge    = (rem_shift >= {1'b0, dvs_q});
    iter_rem  = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    iter_dvd  = {dvd_q[WIDTH-2:0], rem_ge};
  end

  // After a successful subtract the remainder is below the divisor, so the
  // top bit of the difference is always zero and never needs storing.
  assign unused_sub_msb = rem_sub[WIDTH];

  // A new request is only taken when no division is running.
  assign accept = start && (state_q != RUN);

  // Next-state and datapath control for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    q_d        = q_q;
    r_d        = r_q;
    div_zero_d = div_zero_q;

    case (state_q)
      RUN: begin
        dvd_d = iter_dvd;
        rem_d = iter_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          q_d        = iter_dvd;
          r_d        = iter_rem;
          div_zero_d = (dvs_q == '0);
        end
      end
      default: begin
        if (accept) begin
          dvd_d      = dividend;
          dvs_d      = divisor;
          rem_d      = '0;
          cnt_d      = CNT_W'(WIDTH);
          div_zero_d = 1'b0;
          state_d    = RUN;
`ifdef DIVU_ZERO_FAST_EN
          if (divisor == '0) begin
            state_d    = DONE;
            cnt_d      = '0;
            q_d        = '1;
            r_d        = dividend;
            div_zero_d = 1'b1;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      r_q        <= r_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign div_zero = div_zero_q;

endmodule

// File: doc/divu.md
DIVU -- requirements
Module: divu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, the operand and result width in bits (legal range 2..64).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL provide port start  input  1  request a division; sampled at each rising edge.
REQ-005 SHALL provide port dividend  input  WIDTH  unsigned dividend, sampled only on an accepted start.
REQ-006 SHALL provide port divisor  input  WIDTH  unsigned divisor, sampled only on an accepted start.
REQ-007 SHALL provide port q  output  WIDTH  unsigned quotient, registered.
REQ-008 SHALL provide port r  output  WIDTH  unsigned remainder, registered.
REQ-009 SHALL provide port busy  output  1  high while a division is in progress.
REQ-010 SHALL provide port done  output  1  one-cycle pulse marking valid q/r.
REQ-011 SHALL provide port div_zero  output  1  high together with done when the accepted divisor was 0; held until the next accepted start.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept start when the state is IDLE or DONE (busy low); acceptance latches both operands, loads the iteration counter with WIDTH, clears div_zero and enters RUN.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL perform one restoring shift-subtract iteration per clock in RUN, using a WIDTH+1-bit partial remainder; the counter decrements by one per iteration.
REQ-016 SHALL move from RUN to DONE on the edge that completes the WIDTH-th iteration, so done is high exactly WIDTH cycles after the accepting edge.
REQ-017 SHALL hold DONE for exactly one cycle, then go to IDLE, unless start is accepted in that cycle, in which case it goes directly to RUN.
REQ-018 SHALL drive busy high exactly in RUN and done high exactly in DONE.
REQ-019 SHALL update q and r only on the edge entering DONE, and hold them stable through IDLE and any following RUN until the next DONE.
REQ-020 SHALL satisfy dividend = q*divisor + r and r < divisor for every divisor other than 0.
REQ-021 SHALL produce q = all ones, r = dividend and div_zero = 1 for divisor 0.
REQ-022 SHALL update q, r and done correctly for back-to-back starts, with no lost or merged results.

Reset
REQ-023 SHALL, while rst is high at a rising edge, enter IDLE, clear q, r, busy, done, div_zero and the counter to 0, and discard any operation in progress, regardless of start.
REQ-024 SHALL accept a start on the first edge after rst deasserts.

Configuration
REQ-025 SHALL compile in the fast zero-divisor path only when macro DIVU_ZERO_FAST_EN is defined.
- With DIVU_ZERO_FAST_EN: an accepted start with divisor 0 goes directly to DONE on the next edge (done 1 cycle after acceptance), with the REQ-021 results and busy high for 0 cycles.
- Without DIVU_ZERO_FAST_EN: divisor 0 takes the full WIDTH-cycle RUN path and yields the same REQ-021 results.

Verification (WIDTH=32)
REQ-026 SHALL check: dividend=12, divisor=9, start pulse -> busy 32 cycles; done pulse at cycle 32 with q=1, r=3, div_zero=0.
REQ-027 SHALL check: 54/6 followed by 5/6 issued in the done cycle -> q=9, r=0, then 32 cycles later q=0, r=5, with no idle gap.
REQ-028 SHALL check: 0xFFFFFFFF/1 and 0xFFFFFFFF/0xFFFFFFFF -> q=0xFFFFFFFF, r=0, then q=1, r=0.
REQ-029 SHALL check: 100/0 -> q=0xFFFFFFFF, r=100, div_zero=1; done at cycle 1 with DIVU_ZERO_FAST_EN, at cycle 32 without.
REQ-030 SHALL check: start 20/3 with operands changed to 7/2 and start re-pulsed at cycle 10 -> second start ignored; result q=6, r=2.
REQ-031 SHALL check: rst at cycle 15 of a run -> all outputs 0 on the next edge; no done pulse; a new 9/4 start then gives q=2, r=1.
